// File: rtl/rcfwl_gclk_dop_div_seq_if.sv
// -----------------------------------------------------------------------------
// rcfwl_gclk_dop_div_seq_if
//
// Requester <-> sequencer handshake for the grid drop-off-point clock divider.
// The requester (master) presents a divisor and holds a level request until it
// sees the one-cycle acknowledge. The sequencer (slave) reports busy and the
// divisor currently applied to the divider.
//
// Signals:
//   div_req   master->slave  divisor change request (level)
//   div_val   master->slave  requested divisor, 0 is treated as 1
//   div_ack   slave->master  one-cycle completion pulse
//   div_busy  slave->master  sequence in progress
//   div_cur   slave->master  divisor currently applied to the divider
// -----------------------------------------------------------------------------
interface rcfwl_gclk_dop_div_seq_if #(
  parameter int DIVBITS = 4
);

  logic               div_req;
  logic [DIVBITS-1:0] div_val;
  logic               div_ack;
  logic               div_busy;
  logic [DIVBITS-1:0] div_cur;

  modport master (
    output div_req,
    output div_val,
    input  div_ack,
    input  div_busy,
    input  div_cur
  );

  modport slave (
    input  div_req,
    input  div_val,
    output div_ack,
    output div_busy,
    output div_cur
  );

endinterface

// File: rtl/rcfwl_gclk_dop_div_seq.sv
// -----------------------------------------------------------------------------
// rcfwl_gclk_dop_div_seq
//
// Sequencer in front of the grid drop-off-point clock divider. It owns the
// divider's divisor, its active-low alignment reset and the downstream
// clock-gate enable. Every divisor change runs the same ordered sequence:
//
//   GATE      clk_en low for GATE_CYC cycles
//   WAIT_SYNC wait for a USYNC rising edge (bounded by TMO_CYC, else sync_err)
//   ALIGN     one cycle: new divisor applied, div_rst_b pulsed low
//   SETTLE    SETTLE_CYC cycles for the divider to restart
//   ACK       clk_en back high, div_ack pulsed
//
// The same sequence runs once out of reset (the "init pass") without a request
// and without an acknowledge, so the divided clock always starts USYNC-aligned.
// A request for the divisor already applied skips straight to ACK.
//
// Ports:
//   clk        in   primary grid clock
//   rst_b      in   synchronous, active-low reset
//   usync      in   alignment strobe, synchronous to clk
//   req_if     slave side of the divisor handshake (div_req, div_val,
//              div_ack, div_busy, div_cur)
//   div_rst_b  out  divider reset, active-low
//   clk_en     out  downstream clock-gate enable
//   sync_err   out  sticky USYNC-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module rcfwl_gclk_dop_div_seq #(
  parameter int DIVBITS    = 4,
  parameter int DEF_DIV    = 2,
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int TMO_CYC    = 255
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    usync,
  rcfwl_gclk_dop_div_seq_if.slave req_if,
  output logic                    div_rst_b,
  output logic                    clk_en,
  output logic                    sync_err
);

  // ---------------------------------------------------------------------------
  // Counter sizing: one counter serves GATE, WAIT_SYNC and SETTLE. Each state
  // leaves at count N-1, so the counter never needs to hold its largest limit.
  // ---------------------------------------------------------------------------
  localparam int MAX_GS  = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_MAX = (TMO_CYC > MAX_GS) ? TMO_CYC : MAX_GS;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TMO_CYC - 1);

  // A zero divisor would stop the divider, so it is always promoted to 1.
  localparam logic [DIVBITS-1:0] DEF_NORM =
    (DEF_DIV == 0) ? DIVBITS'(1) : DIVBITS'(DEF_DIV);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GATE      = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_ALIGN     = 3'd3,
    S_SETTLE    = 3'd4,
    S_ACK       = 3'd5
  } state_t;

  function automatic logic [DIVBITS-1:0] norm_div(input logic [DIVBITS-1:0] x);
    return (x == '0) ? DIVBITS'(1) : x;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_en;
  logic               init_q;     // set on reset: current pass is the init pass
  logic               run_q;      // low while reset is being applied
  logic               usync_q;
  logic               sync_rise;
  logic               tmo_hit;
  logic               sync_err_q;
  logic [DIVBITS-1:0] div_cur_q;
  logic [DIVBITS-1:0] pend_q;     // divisor waiting to be applied in ALIGN
  logic [DIVBITS-1:0] req_norm;

  logic               ack_o;
  logic               busy_o;
  logic               div_rst_b_o;
  logic               clk_en_o;

  assign req_norm  = norm_div(req_if.div_val);

  // usync_q resets to 1 so a strobe held high through reset is not an edge.
  assign sync_rise = usync & ~usync_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_if.div_req) begin
          state_d = (req_norm == div_cur_q) ? S_ACK : S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q == GATE_LAST) state_d = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        // A rise in the final timeout cycle wins, so no error is flagged.
        if (sync_rise) begin
          state_d = S_ALIGN;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ALIGN;
          tmo_hit = 1'b1;
        end
      end
      S_ALIGN: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt_en = (state_q == S_GATE) || (state_q == S_WAIT_SYNC) ||
                  (state_q == S_SETTLE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_GATE;
      init_q     <= 1'b1;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      usync_q    <= 1'b1;
      sync_err_q <= 1'b0;
      div_cur_q  <= DEF_NORM;
      pend_q     <= DEF_NORM;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      usync_q <= usync;

      // The counter restarts on every state change, which also clears the
      // timeout count on entry to WAIT_SYNC.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if ((state_q == S_IDLE) && (state_d == S_GATE)) begin
        pend_q <= req_norm;
      end

      // Loaded on the edge into ALIGN so the new divisor is already visible
      // during the single div_rst_b low cycle. The init pass keeps DEF_DIV.
      if ((state_d == S_ALIGN) && !init_q) begin
        div_cur_q <= pend_q;
      end

      if (tmo_hit) begin
        sync_err_q <= 1'b1;
      end

      if (state_q == S_ACK) begin
        init_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, decoded from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_o       = 1'b0;
    busy_o      = 1'b1;
    div_rst_b_o = 1'b1;
    clk_en_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o   = 1'b0;
        clk_en_o = 1'b1;
      end
      S_ALIGN: begin
        div_rst_b_o = 1'b0;
      end
      S_ACK: begin
        clk_en_o = 1'b1;
        ack_o    = ~init_q;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
    // Reset parks the FSM in GATE; run_q keeps the divider held in reset
    // until rst_b is released.
    if (!run_q) begin
      div_rst_b_o = 1'b0;
    end
  end

  assign req_if.div_ack  = ack_o;
  assign req_if.div_busy = busy_o;
  assign req_if.div_cur  = div_cur_q;
  assign div_rst_b       = div_rst_b_o;
  assign clk_en          = clk_en_o;
  assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_rcfwl_gclk_dop_div_seq.sv
// -----------------------------------------------------------------------------
// tb_rcfwl_gclk_dop_div_seq
//
// Directed bench for the divider sequencer with default parameters
// (DIVBITS=4, DEF_DIV=2, GATE_CYC=4, SETTLE_CYC=2, TMO_CYC=255).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Cycle k of a run is the cycle following the k-th rising edge
// after the request (or reset release) was driven.
// -----------------------------------------------------------------------------
module tb_rcfwl_gclk_dop_div_seq;

  logic clk;
  logic rst_b;
  logic usync;
  logic div_rst_b;
  logic clk_en;
  logic sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations gathered by run_seq.
  int r_rst_low_n;
  int r_rst_low_k;
  int r_cur_at_low;
  int r_ack_n;
  int r_ack_k;
  int r_en_low_n;
  int r_en_first_low;
  int r_en_last_low;
  int r_err_first;
  int r_err_low_n;

  rcfwl_gclk_dop_div_seq_if #(.DIVBITS(4)) bus ();

  rcfwl_gclk_dop_div_seq #(
    .DIVBITS   (4),
    .DEF_DIV   (2),
    .GATE_CYC  (4),
    .SETTLE_CYC(2),
    .TMO_CYC   (255)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .usync    (usync),
    .req_if   (bus),
    .div_rst_b(div_rst_b),
    .clk_en   (clk_en),
    .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs n cycles. If per > 0, usync is high in cycles where k % per == ph,
  // otherwise usync is left as is. div_val switches to chg_val at cycle chg_k
  // (0 = never). div_req is dropped on the edge after div_ack is seen.
  task automatic run_seq(input int n, input int per, input int ph,
                         input int chg_k, input logic [3:0] chg_val);
    bit drop_req;
    drop_req       = 1'b0;
    r_rst_low_n    = 0;
    r_rst_low_k    = 0;
    r_cur_at_low   = -1;
    r_ack_n        = 0;
    r_ack_k        = 0;
    r_en_low_n     = 0;
    r_en_first_low = 0;
    r_en_last_low  = 0;
    r_err_first    = 0;
    r_err_low_n    = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (drop_req) begin
        bus.div_req = 1'b0;
        drop_req    = 1'b0;
      end
      if (k == chg_k) bus.div_val = chg_val;
      if (per > 0) usync = ((k % per) == ph);
      @(negedge clk);
      if (div_rst_b === 1'b0) begin
        r_rst_low_n++;
        if (r_rst_low_k == 0) begin
          r_rst_low_k  = k;
          r_cur_at_low = int'(bus.div_cur);
        end
      end
      if (bus.div_ack === 1'b1) begin
        r_ack_n++;
        if (r_ack_k == 0) r_ack_k = k;
        drop_req = 1'b1;
      end
      if (clk_en === 1'b0) begin
        r_en_low_n++;
        if (r_en_first_low == 0) r_en_first_low = k;
        r_en_last_low = k;
      end
      if (sync_err === 1'b1) begin
        if (r_err_first == 0) r_err_first = k;
      end else begin
        r_err_low_n++;
      end
    end
  endtask

  task automatic start_req(input logic [3:0] val);
    @(posedge clk);
    #1;
    bus.div_req = 1'b1;
    bus.div_val = val;
  endtask

  // Reset values, then the init pass with a USYNC rise 10 cycles after release.
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (div_rst_b !== 1'b0) begin n_fail++; $display("FAIL reset_div_rst_b: got %b expected 0", div_rst_b); end
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    n_checks++; if (bus.div_ack !== 1'b0) begin n_fail++; $display("FAIL reset_div_ack: got %b expected 0", bus.div_ack); end
    n_checks++; if (bus.div_busy !== 1'b1) begin n_fail++; $display("FAIL reset_div_busy: got %b expected 1", bus.div_busy); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    n_checks++; if (bus.div_cur !== 4'd2) begin n_fail++; $display("FAIL reset_div_cur: got %0d expected 2", bus.div_cur); end
    @(posedge clk);
    #1 rst_b = 1'b1;
    run_seq(20, 100, 10, 0, 4'd0);
    n_checks++; if (r_rst_low_n !== 1) begin n_fail++; $display("FAIL init_rst_low_count: got %0d expected 1", r_rst_low_n); end
    n_checks++; if (r_rst_low_k !== 11) begin n_fail++; $display("FAIL init_align_cycle: got %0d expected 11", r_rst_low_k); end
    n_checks++; if (r_en_last_low !== 13) begin n_fail++; $display("FAIL init_clk_en_rise: got %0d expected 13", r_en_last_low); end
    n_checks++; if (r_ack_n !== 0) begin n_fail++; $display("FAIL init_no_ack: got %0d expected 0", r_ack_n); end
    n_checks++; if (bus.div_cur !== 4'd2) begin n_fail++; $display("FAIL init_div_cur: got %0d expected 2", bus.div_cur); end
    n_checks++; if (bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_end: got %b expected 0", bus.div_busy); end
  endtask

  // 2 -> 5 with a USYNC pulse every 16 cycles (pulses at 3, 19, ...).
  task automatic test_change();
    start_req(4'd5);
    run_seq(30, 16, 3, 0, 4'd0);
    n_checks++; if (r_en_first_low !== 1) begin n_fail++; $display("FAIL chg_gate_start: got %0d expected 1", r_en_first_low); end
    n_checks++; if (r_rst_low_k !== 20) begin n_fail++; $display("FAIL chg_align_cycle: got %0d expected 20", r_rst_low_k); end
    n_checks++; if (r_rst_low_n !== 1) begin n_fail++; $display("FAIL chg_rst_low_count: got %0d expected 1", r_rst_low_n); end
    n_checks++; if (r_cur_at_low !== 5) begin n_fail++; $display("FAIL chg_cur_at_align: got %0d expected 5", r_cur_at_low); end
    n_checks++; if (r_ack_k !== 23) begin n_fail++; $display("FAIL chg_ack_cycle: got %0d expected 23", r_ack_k); end
    n_checks++; if (r_ack_n !== 1) begin n_fail++; $display("FAIL chg_ack_count: got %0d expected 1", r_ack_n); end
    n_checks++; if (r_en_low_n !== 22) begin n_fail++; $display("FAIL chg_gate_len: got %0d expected 22", r_en_low_n); end
    n_checks++; if (bus.div_busy !== 1'b0) begin n_fail++; $display("FAIL chg_busy_end: got %b expected 0", bus.div_busy); end
  endtask

  // Same-value request, then 5 -> 0 (applied as 1), then 0 against div_cur=1.
  task automatic test_same_value();
    start_req(4'd5);
    run_seq(6, 0, 0, 0, 4'd0);
    n_checks++; if (r_ack_k !== 1) begin n_fail++; $display("FAIL same5_ack_cycle: got %0d expected 1", r_ack_k); end
    n_checks++; if (r_ack_n !== 1) begin n_fail++; $display("FAIL same5_ack_count: got %0d expected 1", r_ack_n); end
    n_checks++; if (r_en_low_n !== 0) begin n_fail++; $display("FAIL same5_no_gate: got %0d expected 0", r_en_low_n); end
    n_checks++; if (r_rst_low_n !== 0) begin n_fail++; $display("FAIL same5_no_rst: got %0d expected 0", r_rst_low_n); end
    start_req(4'd0);
    run_seq(30, 16, 3, 0, 4'd0);
    n_checks++; if (r_cur_at_low !== 1) begin n_fail++; $display("FAIL zero_norm_cur: got %0d expected 1", r_cur_at_low); end
    n_checks++; if (r_ack_k !== 23) begin n_fail++; $display("FAIL zero_ack_cycle: got %0d expected 23", r_ack_k); end
    start_req(4'd0);
    run_seq(6, 0, 0, 0, 4'd0);
    n_checks++; if (r_ack_k !== 1) begin n_fail++; $display("FAIL same0_ack_cycle: got %0d expected 1", r_ack_k); end
    n_checks++; if (r_en_low_n !== 0) begin n_fail++; $display("FAIL same0_no_gate: got %0d expected 0", r_en_low_n); end
    n_checks++; if (r_rst_low_n !== 0) begin n_fail++; $display("FAIL same0_no_rst: got %0d expected 0", r_rst_low_n); end
    n_checks++; if (bus.div_cur !== 4'd1) begin n_fail++; $display("FAIL same0_div_cur: got %0d expected 1", bus.div_cur); end
  endtask

  // usync stuck low: WAIT_SYNC entered at cycle 5, ALIGN 255 cycles later.
  task automatic test_sync_timeout();
    start_req(4'd9);
    run_seq(270, 0, 0, 0, 4'd0);
    n_checks++; if (r_rst_low_k !== 260) begin n_fail++; $display("FAIL tmo_align_cycle: got %0d expected 260", r_rst_low_k); end
    n_checks++; if (r_err_first !== 260) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d expected 260", r_err_first); end
    n_checks++; if (r_cur_at_low !== 9) begin n_fail++; $display("FAIL tmo_cur_at_align: got %0d expected 9", r_cur_at_low); end
    n_checks++; if (r_ack_k !== 263) begin n_fail++; $display("FAIL tmo_ack_cycle: got %0d expected 263", r_ack_k); end
    start_req(4'd3);
    run_seq(30, 16, 3, 0, 4'd0);
    n_checks++; if (r_rst_low_k !== 20) begin n_fail++; $display("FAIL post_tmo_align: got %0d expected 20", r_rst_low_k); end
    n_checks++; if (r_ack_n !== 1) begin n_fail++; $display("FAIL post_tmo_ack: got %0d expected 1", r_ack_n); end
    n_checks++; if (r_err_low_n !== 0) begin n_fail++; $display("FAIL post_tmo_err_sticky: got %0d expected 0", r_err_low_n); end
    n_checks++; if (bus.div_cur !== 4'd3) begin n_fail++; $display("FAIL post_tmo_div_cur: got %0d expected 3", bus.div_cur); end
  endtask

  // 3 -> 5, then reset during SETTLE of 5 -> 3 with usync held high.
  task automatic test_reset_mid();
    start_req(4'd5);
    run_seq(30, 16, 3, 0, 4'd0);
    n_checks++; if (r_ack_k !== 23) begin n_fail++; $display("FAIL mid_pre_ack: got %0d expected 23", r_ack_k); end
    start_req(4'd3);
    run_seq(21, 16, 3, 0, 4'd0);
    n_checks++; if (r_cur_at_low !== 3) begin n_fail++; $display("FAIL mid_cur_at_align: got %0d expected 3", r_cur_at_low); end
    #1;
    rst_b       = 1'b0;
    usync       = 1'b1;
    bus.div_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.div_ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack: got %b expected 0", bus.div_ack); end
      n_checks++; if (div_rst_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_div_rst_b: got %b expected 0", div_rst_b); end
      n_checks++; if (bus.div_cur !== 4'd2) begin n_fail++; $display("FAIL mid_rst_div_cur: got %0d expected 2", bus.div_cur); end
    end
    @(posedge clk);
    #1 rst_b = 1'b1;
    run_seq(20, 0, 0, 0, 4'd0);
    n_checks++; if (r_rst_low_n !== 0) begin n_fail++; $display("FAIL mid_high_no_align: got %0d expected 0", r_rst_low_n); end
    n_checks++; if (r_en_low_n !== 20) begin n_fail++; $display("FAIL mid_high_gated: got %0d expected 20", r_en_low_n); end
    n_checks++; if (r_ack_n !== 0) begin n_fail++; $display("FAIL mid_high_no_ack: got %0d expected 0", r_ack_n); end
    run_seq(10, 4, 0, 0, 4'd0);
    n_checks++; if (r_rst_low_k !== 5) begin n_fail++; $display("FAIL mid_init_align: got %0d expected 5", r_rst_low_k); end
    n_checks++; if (r_rst_low_n !== 1) begin n_fail++; $display("FAIL mid_init_rst_count: got %0d expected 1", r_rst_low_n); end
    n_checks++; if (r_ack_n !== 0) begin n_fail++; $display("FAIL mid_init_no_ack: got %0d expected 0", r_ack_n); end
    n_checks++; if (r_en_last_low !== 7) begin n_fail++; $display("FAIL mid_init_ungate: got %0d expected 7", r_en_last_low); end
    n_checks++; if (bus.div_cur !== 4'd2) begin n_fail++; $display("FAIL mid_init_div_cur: got %0d expected 2", bus.div_cur); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL mid_sync_err_clear: got %b expected 0", sync_err); end
  endtask

  // Rise in the very last timeout cycle (cycle 259) counts as a rise.
  task automatic test_tmo_tie();
    start_req(4'd4);
    run_seq(270, 1000, 259, 0, 4'd0);
    n_checks++; if (r_rst_low_k !== 260) begin n_fail++; $display("FAIL tie_align_cycle: got %0d expected 260", r_rst_low_k); end
    n_checks++; if (r_err_first !== 0) begin n_fail++; $display("FAIL tie_no_err: got %0d expected 0", r_err_first); end
    n_checks++; if (r_cur_at_low !== 4) begin n_fail++; $display("FAIL tie_cur_at_align: got %0d expected 4", r_cur_at_low); end
  endtask

  // div_val moves 6 -> 7 while the 6 request is in flight.
  task automatic test_busy_change();
    start_req(4'd6);
    run_seq(30, 16, 3, 2, 4'd7);
    n_checks++; if (r_cur_at_low !== 6) begin n_fail++; $display("FAIL busy_cur_at_align: got %0d expected 6", r_cur_at_low); end
    n_checks++; if (r_ack_n !== 1) begin n_fail++; $display("FAIL busy_ack_count: got %0d expected 1", r_ack_n); end
    n_checks++; if (r_rst_low_n !== 1) begin n_fail++; $display("FAIL busy_rst_count: got %0d expected 1", r_rst_low_n); end
    n_checks++; if (bus.div_cur !== 4'd6) begin n_fail++; $display("FAIL busy_div_cur_end: got %0d expected 6", bus.div_cur); end
  endtask

  initial begin
    rst_b       = 1'b0;
    usync       = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = 4'd0;
    test_reset();
    test_change();
    test_same_value();
    test_sync_timeout();
    test_reset_mid();
    test_tmo_tie();
    test_busy_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
